// File: rtl/ram16x4_access_ctrl_pkg.sv
// rtl/ram16x4_access_ctrl_pkg.sv - shared widths, state encoding and port ids for the RAM access controller
package ram16x4_access_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_ACK   = 2'b10
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic logic [1:0] onehot_port(input logic id);
        return (id == PORT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram16x4_access_ctrl_rr_arbiter_2.sv
// rtl/ram16x4_access_ctrl_rr_arbiter_2.sv - two-way round-robin arbiter
// ptr names the port that wins a tie; the top flips it after each completed access.
module rr_arbiter_2
    import ram16x4_access_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = PORT0;
        grant  = 2'b00;
        case (req)
            2'b01:   winner = PORT0;
            2'b10:   winner = PORT1;
            2'b11:   winner = ptr;
            default: winner = PORT0;
        endcase
        if (req != 2'b00) begin
            grant = onehot_port(winner);
        end
    end

endmodule

// File: rtl/ram16x4_access_ctrl.sv
// rtl/ram16x4_access_ctrl.sv - round-robin two-port access controller for a shared 16x4 register RAM
// One access at a time: IDLE samples a request, GRANT drives the RAM, ACK returns the result.
module ram16x4_access_ctrl
    import ram16x4_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_dout
);

    state_t state;
    logic   ptr;
    logic   lat_id;
    logic   lat_we;
    logic   winner;
    logic [1:0] grant;

    rr_arbiter_2 u_arb (
        .req    (req),
        .ptr    (ptr),
        .grant  (grant),
        .winner (winner)
    );

    // ram_addr/ram_din double as the latched address/data, so they hold in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= PORT0;
            lat_id   <= PORT0;
            lat_we   <= 1'b0;
            ack      <= 2'b00;
            busy     <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack    <= 2'b00;
                    ram_we <= 1'b0;
                    if (|grant) begin
                        lat_id   <= winner;
                        lat_we   <= we[winner];
                        ram_we   <= we[winner];
                        ram_addr <= winner ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
                        ram_din  <= winner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
                        busy     <= 1'b1;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    ram_we <= 1'b0;
                    if (!lat_we) begin
                        rdata <= ram_dout;
                    end
                    ack   <= onehot_port(lat_id);
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    ack   <= 2'b00;
                    busy  <= 1'b0;
                    ptr   <= ~lat_id;
                    state <= ST_IDLE;
                end
                default: begin
                    ack    <= 2'b00;
                    busy   <= 1'b0;
                    ram_we <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram16x4_access_ctrl.sv
// tb/tb_ram16x4_access_ctrl.sv - self-checking bench for ram16x4_access_ctrl with a transaction-level model
module tb_ram16x4_access_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [1:0] ack;
    logic [3:0] rdata;
    logic       busy;
    logic [3:0] ram_addr;
    logic [3:0] ram_din;
    logic       ram_we;
    logic [3:0] ram_dout;

    logic [3:0] mem    [16];
    logic [3:0] shadow [16];
    logic       fill;

    int   checks = 0;
    int   errors = 0;
    logic last;
    logic [3:0] exp_rdata;

    ram16x4_access_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .ack      (ack),
        .rdata    (rdata),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 16; i++) mem[i] <= shadow[i];
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
    end
    assign ram_dout = mem[ram_addr];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic w, input logic [3:0] a, input logic [3:0] d);
        we[p]          = w;
        addr[p*4 +: 4]  = a;
        wdata[p*4 +: 4] = d;
    endtask

    task automatic rand_port(input int p);
        set_port(p, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
    endtask

    task automatic model_reset;
        last      = 1'b1;
        exp_rdata = 4'h0;
    endtask

    // Serves n accesses; the model picks the winner from the pending set and the port served last.
    task automatic serve(input int n, input bit refill, input bit perturb);
        for (int k = 0; k < n; k++) begin
            logic       w;
            logic       lw;
            logic [3:0] a;
            logic [3:0] d;
            int         idx;
            w   = (req == 2'b11) ? ~last : req[1];
            idx = w ? 4 : 0;
            lw  = we[w];
            a   = addr[idx +: 4];
            d   = wdata[idx +: 4];
            tick;
            chk("grant_busy", 8'(busy), 8'd1);
            chk("grant_ram_we", 8'(ram_we), 8'(lw));
            chk("grant_ram_addr", 8'(ram_addr), 8'(a));
            if (lw) chk("grant_ram_din", 8'(ram_din), 8'(d));
            chk("grant_ack", 8'(ack), 8'd0);
            if (perturb) rand_port(int'(w));
            tick;
            chk("ack_port", 8'(ack), w ? 8'd2 : 8'd1);
            chk("ack_ram_we", 8'(ram_we), 8'd0);
            if (lw) shadow[a] = d;
            else    exp_rdata = shadow[a];
            chk("ack_rdata", 8'(rdata), 8'(exp_rdata));
            chk("ram_word", 8'(mem[a]), 8'(shadow[a]));
            req[w] = 1'b0;
            last   = w;
            tick;
            chk("idle_ack", 8'(ack), 8'd0);
            chk("idle_busy", 8'(busy), 8'd0);
            chk("idle_ram_we", 8'(ram_we), 8'd0);
            chk("idle_ram_addr", 8'(ram_addr), 8'(a));
            if (refill) begin
                rand_port(int'(w));
                req[w] = 1'b1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = 4'($urandom);
        fill  = 1'b1;
        req   = 2'b00;
        we    = 2'b00;
        addr  = 8'h00;
        wdata = 8'h00;
        reset = 1'b1;
        model_reset();
        tick;
        tick;
        fill = 1'b0;
        chk("rst_ack", 8'(ack), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_ram_we", 8'(ram_we), 8'd0);
        chk("rst_ram_addr", 8'(ram_addr), 8'd0);
        chk("rst_ram_din", 8'(ram_din), 8'd0);
        chk("rst_rdata", 8'(rdata), 8'd0);
        reset = 1'b0;

        // reset lands in the middle of a port-0 write to word 3
        set_port(0, 1'b1, 4'd3, 4'hA);
        req = 2'b01;
        tick;
        chk("midrst_pre_we", 8'(ram_we), 8'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ram_we", 8'(ram_we), 8'd0);
        chk("midrst_busy", 8'(busy), 8'd0);
        chk("midrst_ack", 8'(ack), 8'd0);
        chk("midrst_ram_addr", 8'(ram_addr), 8'd0);
        req = 2'b00;
        tick;
        chk("midrst_word3", 8'(mem[3]), 8'(shadow[3]));
        chk("midrst_ack2", 8'(ack), 8'd0);
        #2 reset = 1'b0;
        model_reset();

        // contention from reset: port 0, then port 1, then port 0 again
        rand_port(0);
        rand_port(1);
        req = 2'b11;
        serve(2, 1'b0, 1'b0);
        rand_port(0);
        rand_port(1);
        req = 2'b11;
        serve(2, 1'b0, 1'b0);

        // port 1 writes then reads the top word
        set_port(1, 1'b1, 4'd15, 4'h5);
        req = 2'b10;
        serve(1, 1'b0, 1'b0);
        set_port(1, 1'b0, 4'd15, 4'h0);
        req = 2'b10;
        serve(1, 1'b0, 1'b0);
        chk("rd15_rdata", 8'(rdata), 8'h05);

        // both held for six accesses: strict alternation, three cycles each
        rand_port(0);
        rand_port(1);
        req = 2'b11;
        serve(6, 1'b1, 1'b0);
        req = 2'b00;

        // read of word 7 queued behind the other port's write to it
        set_port(0, 1'b1, 4'd7, 4'hC);
        set_port(1, 1'b0, 4'd7, 4'h0);
        req = 2'b11;
        serve(2, 1'b0, 1'b0);
        chk("serial_rdata", 8'(rdata), 8'h0C);

        // random traffic with inputs disturbed during GRANT
        rand_port(0);
        rand_port(1);
        req = 2'($urandom_range(1, 3));
        serve(24, 1'b1, 1'b1);
        req = 2'b00;
        tick;
        chk("end_idle_we", 8'(ram_we), 8'd0);
        chk("end_idle_busy", 8'(busy), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
